// File: rtl/caf_lag_ctrl.sv
// caf_lag_ctrl: sweeps a lag index, handing each lag to the x/y window and
// dot-product logic and tracking the lag whose |i|+|q| product is largest.
//
// state  | meaning
// IDLE   | waiting for start; peak results from the last sweep are held
// ISSUE  | one-cycle x/y window valid pulse for the current lag
// WAIT   | waiting for the dot-product result, bounded by timeout cycles
// CMP    | update peak with the registered magnitude, step the lag or finish
// DONE   | one-cycle done pulse, then back to IDLE
module caf_lag_ctrl #(
  parameter int i_bits   = 24,
  parameter int q_bits   = 24,
  parameter int lag_bits = 8,
  parameter int max_lag  = 15,
  parameter int timeout  = 64,
  localparam int mag_bits = ((i_bits > q_bits) ? i_bits : q_bits) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [lag_bits-1:0] lag,
  output logic                m_axis_x_tvalid,
  output logic                m_axis_y_tvalid,
  output logic                m_axis_product_tready,
  input  logic                s_axis_product_tvalid,
  input  logic [i_bits-1:0]   i,
  input  logic [q_bits-1:0]   q,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [lag_bits-1:0] peak_lag,
  output logic [mag_bits-1:0] peak_mag
);

  localparam int cnt_bits = $clog2(timeout + 1);
  localparam logic [cnt_bits-1:0] CNT_LAST = cnt_bits'(timeout - 1);
  localparam logic [lag_bits-1:0] LAG_LAST = lag_bits'(max_lag);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [lag_bits-1:0] r_lag;
  logic                r_xy_valid;
  logic                r_tready;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout_err;
  logic [lag_bits-1:0] r_peak_lag;
  logic [mag_bits-1:0] r_peak_mag;
  logic [mag_bits-1:0] r_mag;
  logic [cnt_bits-1:0] r_wait_cnt;

  logic [i_bits-1:0]   w_abs_i;
  logic [q_bits-1:0]   w_abs_q;
  logic [mag_bits-1:0] w_mag;

  // Two's-complement negate as unsigned: the most negative input maps to
  // exactly 2^(bits-1), which still fits in the unsigned width.
  assign w_abs_i = i[i_bits-1] ? (~i + {{(i_bits-1){1'b0}}, 1'b1}) : i;
  assign w_abs_q = q[q_bits-1] ? (~q + {{(q_bits-1){1'b0}}, 1'b1}) : q;
  assign w_mag   = {{(mag_bits-i_bits){1'b0}}, w_abs_i}
                 + {{(mag_bits-q_bits){1'b0}}, w_abs_q};

  // Sweep sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lag         <= '0;
      r_xy_valid    <= 1'b0;
      r_tready      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_peak_lag    <= '0;
      r_peak_mag    <= '0;
      r_mag         <= '0;
      r_wait_cnt    <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Cancel drops handshakes immediately but keeps peak results.
      r_state    <= S_IDLE;
      r_xy_valid <= 1'b0;
      r_tready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !abort) begin
            r_state       <= S_ISSUE;
            r_lag         <= '0;
            r_peak_lag    <= '0;
            r_peak_mag    <= '0;
            r_timeout_err <= 1'b0;
            r_xy_valid    <= 1'b1;
            r_tready      <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_xy_valid <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (s_axis_product_tvalid) begin
            r_mag   <= w_mag;
            r_state <= S_CMP;
          end else if (r_wait_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b1;
            r_tready      <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + cnt_bits'(1);
          end
        end
        S_CMP: begin
          // Strict compare so ties keep the earliest lag; lag 0 always seeds.
          if ((r_mag > r_peak_mag) || (r_lag == '0)) begin
            r_peak_mag <= r_mag;
            r_peak_lag <= r_lag;
          end
          if (r_lag == LAG_LAST) begin
            r_tready <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_lag      <= r_lag + lag_bits'(1);
            r_xy_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_xy_valid <= 1'b0;
          r_tready   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign lag                   = r_lag;
  assign m_axis_x_tvalid       = r_xy_valid;
  assign m_axis_y_tvalid       = r_xy_valid;
  assign m_axis_product_tready = r_tready;
  assign busy                  = r_busy;
  assign done                  = r_done;
  assign timeout_err           = r_timeout_err;
  assign peak_lag              = r_peak_lag;
  assign peak_mag              = r_peak_mag;

endmodule
